mac_tile_feeder: RTL
====================

Name: mac_tile_feeder

Overview:
- Sequencing front end for the 4-lane MAC chain; the other end of its x/w/psum_in interface.
- Accepts a job of len 4-element groups (x vector and w vector) over a valid/ready stream.
- Drives each group into the chain with the running partial sum, captures the chain result, and accumulates.
- Presents the final dot product on a result valid/ready port.

Parameters:
- bw, 4, bit width of each x and w lane
- psum_bw, 16, bit width of partial sum and result
- len_bw, 4, bit width of the group-count field len

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  job start request, sampled only in IDLE
- len  input  len_bw  number of 4-lane groups in the job, sampled with start
- in_valid  input  1  input group valid
- in_ready  output  1  feeder accepts a group this cycle
- in_x  input  4*bw  packed x lanes, lane k at bits [k*bw +: bw]
- in_w  input  4*bw  packed w lanes, same packing
- x0..x3  output  bw each  registered x lanes to the MAC chain
- w0..w3  output  bw each  registered w lanes to the MAC chain
- psum_out  output  psum_bw  registered running sum, drives chain psum_in
- mac_out  input  psum_bw  combinational chain result = psum_out + sum(xk*wk)
- res_valid  output  1  final result valid
- res_ready  input  1  consumer accepts result
- res_data  output  psum_bw  final dot product
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, all x/w lanes=0, psum_out=0, counter=0, in_ready=0, res_valid=0, res_data=0, busy=0. Reset asserted mid-job aborts the job; no partial result is emitted.
- Arithmetic: unsigned. The chain result wraps modulo 2^psum_bw. The feeder adds no extension or saturation.
- FSM, state encoding free:
  - IDLE: if start and len!=0, then psum_out<=0, cnt<=len, go to LOAD. If start and len==0, then psum_out<=0, go to DONE (result 0). All other inputs are ignored.
  - LOAD: in_ready=1 combinationally. On in_valid&in_ready, register in_x/in_w into x0..x3/w0..w3 and go to CAPTURE. Without in_valid, hold state and outputs.
  - CAPTURE: in_ready=0. psum_out<=mac_out; cnt<=cnt-1. If cnt==1 go to DONE, else go to LOAD. x/w lanes hold their values.
  - DONE: res_valid=1, res_data=psum_out. On res_ready go to IDLE, with res_valid low from the next cycle. res_data stays stable while res_valid is high and not yet accepted.
- Throughput: one group per 2 cycles at most.
- Latency:
  - The first group can be accepted the cycle after start.
  - res_valid rises 1 cycle after the CAPTURE of the last group.
  - Minimum job time is 2*len+1 cycles from start to res_valid.
- start while not IDLE is ignored; len is not re-sampled.
- x/w lanes keep their last values after a job; psum_out holds the final sum until the next start.
- Simultaneous res_ready and start in DONE: start is ignored, because it is only sampled in IDLE.

Test Plan:
- Single group: start, len=1; in_x lanes [1,2,3,4], in_w [1,1,1,1] -> res_valid with res_data=10 exactly 3 cycles after start.
- Two groups, no stalls: len=2; group0 x=[1,2,3,4], w=[2,2,2,2]; group1 x=[15,15,15,15], w=[15,15,15,15] -> res_data=20+900=920. in_ready pattern 1,0,1,0 over the first four cycles after start.
- Input stalls and backpressure: len=3 with in_valid low for 5 cycles before each group, and res_ready held low 4 cycles. Required response:
  - lanes change only on a handshake;
  - res_valid and res_data stay stable until res_ready;
  - busy drops the cycle after acceptance.
- Wrap-around with psum_bw=8: len=2, all lanes 15 -> each group adds 900; 1800 mod 256 = 8 -> res_data=8.
- len=0 and ignored start: start with len=0 -> res_valid next cycle with res_data=0. A start pulse during LOAD of a len=2 job does not alter cnt or psum.
- Reset mid-job: reset_n low during CAPTURE of group 1 of 3. Required response:
  - all outputs go to 0 immediately, without waiting for a clock;
  - after release, a new len=1 job with x=[1,1,1,1], w=[3,3,3,3] yields res_data=12.

Source files
------------

// File: rtl/mac_tile_feeder_if.sv
// Job/result stream bundle between a producer/consumer and the MAC tile feeder.
interface mac_tile_feeder_if #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 4
);
  logic                start;
  logic [len_bw-1:0]   len;
  logic                in_valid;
  logic                in_ready;
  logic [4*bw-1:0]     in_x;
  logic [4*bw-1:0]     in_w;
  logic                res_valid;
  logic                res_ready;
  logic [psum_bw-1:0]  res_data;
  logic                busy;

  modport slave (
    input  start, len, in_valid, in_x, in_w, res_ready,
    output in_ready, res_valid, res_data, busy
  );

  modport master (
    output start, len, in_valid, in_x, in_w, res_ready,
    input  in_ready, res_valid, res_data, busy
  );
endinterface

// File: rtl/mac_tile_feeder.sv
// Sequences len 4-lane x/w groups into the MAC chain, folding each chain
// result back in as the next partial sum, and presents the final dot product.
module mac_tile_feeder #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  mac_tile_feeder_if.slave   bus,
  output logic [bw-1:0]      x0,
  output logic [bw-1:0]      x1,
  output logic [bw-1:0]      x2,
  output logic [bw-1:0]      x3,
  output logic [bw-1:0]      w0,
  output logic [bw-1:0]      w1,
  output logic [bw-1:0]      w2,
  output logic [bw-1:0]      w3,
  output logic [psum_bw-1:0] psum_out,
  input  logic [psum_bw-1:0] mac_out
);

  localparam logic [1:0] st_idle    = 2'd0;
  localparam logic [1:0] st_load    = 2'd1;
  localparam logic [1:0] st_capture = 2'd2;
  localparam logic [1:0] st_done    = 2'd3;

  logic [1:0]         state_reg;
  logic [len_bw-1:0]  cnt_reg;
  logic [psum_bw-1:0] psum_reg;
  logic               in_hs;

  assign bus.in_ready  = (state_reg == st_load);
  assign bus.res_valid = (state_reg == st_done);
  assign bus.busy      = (state_reg != st_idle);
  assign bus.res_data  = psum_reg;
  assign psum_out      = psum_reg;
  assign in_hs         = bus.in_valid && (state_reg == st_load);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= st_idle;
      cnt_reg   <= '0;
      psum_reg  <= '0;
    end else begin
      case (state_reg)
        st_idle: begin
          if (bus.start) begin
            psum_reg <= '0;
            if (bus.len != '0) begin
              cnt_reg   <= bus.len;
              state_reg <= st_load;
            end else begin
              state_reg <= st_done;
            end
          end
        end
        st_load: begin
          if (bus.in_valid) state_reg <= st_capture;
        end
        st_capture: begin
          // mac_out already includes the current psum_out, so it replaces it.
          psum_reg  <= mac_out;
          cnt_reg   <= cnt_reg - 1'b1;
          state_reg <= (cnt_reg == len_bw'(1)) ? st_done : st_load;
        end
        default: begin
          if (bus.res_ready) state_reg <= st_idle;
        end
      endcase
    end
  end

  // Lane registers only move on an accepted group and otherwise hold.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [bw-1:0] x_reg;
    logic [bw-1:0] w_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        x_reg <= '0;
        w_reg <= '0;
      end else if (in_hs) begin
        x_reg <= bus.in_x[gi*bw +: bw];
        w_reg <= bus.in_w[gi*bw +: bw];
      end
    end
  end

  assign x0 = g_lane[0].x_reg;
  assign x1 = g_lane[1].x_reg;
  assign x2 = g_lane[2].x_reg;
  assign x3 = g_lane[3].x_reg;
  assign w0 = g_lane[0].w_reg;
  assign w1 = g_lane[1].w_reg;
  assign w2 = g_lane[2].w_reg;
  assign w3 = g_lane[3].w_reg;

endmodule
